alu_sequencer: RTL and testbench

//  Initiator side of the 32-bit gate-level ALU: accepts ALU requests over valid/ready,

---
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Request/response wrapper around the combinational gate-level ALU: registers operands, waits a
// fixed settle window, then captures the ALU outputs. Define ALU_CHECK_EN to add the result checker.
module alu_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cmd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_mismatch,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, capture, rsp_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == CNT_W'(1)) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (accept)         cnt <= CNT_W'(SETTLE_CYCLES);
    else if (state == SETTLE) cnt <= cnt - CNT_W'(1);
  end

  // ALU inputs only move on accept so the gate network never sees spurious toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cmd <= '0;
    end else if (accept) begin
      alu_a   <= req_a;
      alu_b   <= req_b;
      alu_cmd <= req_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else if (capture) begin
      rsp_valid    <= 1'b1;
      rsp_result   <= alu_result;
      rsp_carryout <= alu_carryout;
      rsp_zero     <= alu_zero;
      rsp_overflow <= alu_overflow;
    end else if (rsp_done) begin
      rsp_valid    <= 1'b0;
    end
  end

`ifdef ALU_CHECK_EN
  // Returns {overflow, zero, carryout, result} for the ALU's command set.
  function automatic logic [WIDTH+2:0] alu_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       cmd);
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH:0]          sum;
    logic [WIDTH-1:0]        res;
    logic                    co, ov, zr;
    sa  = $signed(a);
    sb  = $signed(b);
    sum = '0;
    res = '0;
    co  = 1'b0;
    ov  = 1'b0;
    zr  = 1'b0;
    case (cmd)
      3'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[WIDTH-1:0];
        co  = sum[WIDTH];
        ov  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
        zr  = (res == '0);
      end
      3'd1: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res = sum[WIDTH-1:0];
        co  = sum[WIDTH];
        ov  = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
        zr  = (res == '0);
      end
      3'd2:    res = a ^ b;
      3'd3:    res = {{(WIDTH-1){1'b0}}, (sa < sb)};
      3'd4:    res = a & b;
      3'd5:    res = ~(a & b);
      3'd6:    res = ~(a | b);
      default: res = a | b;
    endcase
    return {ov, zr, co, res};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rsp_mismatch <= 1'b0;
    else if (capture)
      rsp_mismatch <= (alu_model(alu_a, alu_b, alu_cmd) !=
                       {alu_overflow, alu_zero, alu_carryout, alu_result});
    else if (rsp_done)
      rsp_mismatch <= 1'b0;
  end
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a slow ALU stub feeds the DUT, a request-level model predicts
// handshake timing and the captured response. Define ALU_CHECK_EN to exercise the checker.
module tb_alu_sequencer;
  localparam int W = 32;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [W-1:0]  req_a, req_b;
  logic [2:0]    req_cmd;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_cmd;
  logic [W-1:0]  alu_result;
  logic          alu_carryout, alu_zero, alu_overflow;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_carryout, rsp_zero, rsp_overflow, rsp_mismatch, busy;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_mismatch(rsp_mismatch), .busy(busy)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         c, z, o;
  } alu_out_t;

  typedef struct {
    alu_out_t o;
    logic     m;
  } exp_t;

  // ALU behaviour from its definition, using wide integer arithmetic.
  function automatic alu_out_t ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] cmd);
    alu_out_t        o;
    longint          sa, sb, s;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    o  = '0;
    case (cmd)
      3'd0: begin
        o.r = W'(ua + ub);
        o.c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        s   = sa + sb;
        o.o = (s != longint'($signed(o.r)));
        o.z = (o.r == 0);
      end
      3'd1: begin
        o.r = W'(ua - ub);
        o.c = (ua >= ub);
        s   = sa - sb;
        o.o = (s != longint'($signed(o.r)));
        o.z = (o.r == 0);
      end
      3'd2:    o.r = a ^ b;
      3'd3:    o.r = (sa < sb) ? 1 : 0;
      3'd4:    o.r = a & b;
      3'd5:    o.r = ~(a & b);
      3'd6:    o.r = ~(a | b);
      default: o.r = a | b;
    endcase
    return o;
  endfunction

  // Slow ALU stub: outputs are garbage until the inputs have been stable for S-1 clocks.
  int       stub_age = 15;
  logic     stub_bad = 1'b0;
  alu_out_t stub;
  always_comb begin
    stub = ref_alu(alu_a, alu_b, alu_cmd);
    if (stub_age < S - 1) stub = ~stub;
    if (stub_bad) stub.r[0] = ~stub.r[0];
  end
  assign alu_result   = stub.r;
  assign alu_carryout = stub.c;
  assign alu_zero     = stub.z;
  assign alu_overflow = stub.o;

  always @(posedge clk) begin
    if (req_valid && req_ready) stub_age <= 0;
    else if (stub_age < 15)     stub_age <= stub_age + 1;
  end

  int           n_chk = 0, n_fail = 0;
  exp_t         q[$];
  logic         model_busy = 1'b0;
  int           cyc = 0, acc_cyc = 0;
  logic [W-1:0] last_a = '0, last_b = '0;
  logic [2:0]   last_cmd = '0;
  int           bp_mode = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Request/response bookkeeping at the active edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (rsp_valid && rsp_ready && model_busy) begin
        if (q.size() > 0) q.delete(0);
        model_busy = 1'b0;
      end
      if (req_valid && req_ready) begin
        e.o = ref_alu(req_a, req_b, req_cmd);
        if (stub_bad) e.o.r[0] = ~e.o.r[0];
`ifdef ALU_CHECK_EN
        e.m = stub_bad;
`else
        e.m = 1'b0;
`endif
        q.push_back(e);
        last_a     = req_a;
        last_b     = req_b;
        last_cmd   = req_cmd;
        acc_cyc    = cyc;
        model_busy = 1'b1;
      end
    end
  end

  // Monitor: compares every observable output at the inactive edge.
  always @(negedge clk) begin
    logic exp_v;
    if (!rst_n) begin
      q.delete();
      model_busy = 1'b0;
      last_a     = '0;
      last_b     = '0;
      last_cmd   = '0;
      chk("rst_req_ready", W'(req_ready), 1);
      chk("rst_busy", W'(busy), 0);
      chk("rst_rsp_valid", W'(rsp_valid), 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_cmd", W'(alu_cmd), 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_flags", W'({rsp_carryout, rsp_zero, rsp_overflow, rsp_mismatch}), 0);
    end else begin
      exp_v = model_busy && ((cyc - acc_cyc) >= S);
      chk("req_ready", W'(req_ready), W'(!model_busy));
      chk("busy", W'(busy), W'(model_busy));
      chk("alu_a", alu_a, last_a);
      chk("alu_b", alu_b, last_b);
      chk("alu_cmd", W'(alu_cmd), W'(last_cmd));
      chk("rsp_valid", W'(rsp_valid), W'(exp_v));
      if (exp_v && q.size() > 0) begin
        chk("rsp_result", rsp_result, q[0].o.r);
        chk("rsp_carryout", W'(rsp_carryout), W'(q[0].o.c));
        chk("rsp_zero", W'(rsp_zero), W'(q[0].o.z));
        chk("rsp_overflow", W'(rsp_overflow), W'(q[0].o.o));
        chk("rsp_mismatch", W'(rsp_mismatch), W'(q[0].m));
      end
    end
  end

  // Consumer: 0 always ready, 1 random backpressure, 2 stalled.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    int n = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_cmd   = c;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) timeout("req_accept");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (model_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (model_busy) timeout("rsp_drain");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cmd   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(32'hFFFF_FFFF, 32'h0000_0001, 3'd0);
    send(32'h8000_0000, 32'h0000_0001, 3'd1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 3'd3);
    send(32'h0000_0001, 32'hFFFF_FFFF, 3'd3);
    wait_idle();

    // Stalled consumer: response must hold and a second request must be ignored.
    bp_mode = 2;
    send(32'hA5A5_A5A5, 32'h5A5A_0FF0, 3'd7);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) timeout("rsp_valid_stall");
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_a     = 32'h1234_5678;
    req_b     = 32'h0BAD_F00D;
    req_cmd   = 3'd0;
    repeat (5) @(posedge clk);
    #1;
    req_valid = 1'b0;
    bp_mode   = 0;
    wait_idle();

    // Reset while the settle counter is at 2.
    send(32'h0000_0003, 32'h0000_0005, 3'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (S + 3) @(posedge clk);

`ifdef ALU_CHECK_EN
    stub_bad = 1'b1;
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4);
    wait_idle();
    stub_bad = 1'b0;
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4);
    wait_idle();
`endif

    bp_mode = 1;
    for (int i = 0; i < 40; i++) send(pick(), pick(), 3'($urandom_range(0, 7)));
    bp_mode = 0;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
